// File: rtl/inst_mem.sv
// Run-time loadable instruction memory: a sequential load port fills the array,
// and the fetch port returns one registered word per accepted request.
module inst_mem #(
  parameter int unsigned       ADDR_W = 8,
  parameter int unsigned       DATA_W = 8,
  parameter int unsigned       DEPTH  = 256,
  parameter logic [DATA_W-1:0] FILL   = {DATA_W{1'b1}}
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              req_i,
  input  logic [ADDR_W-1:0] address_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              oob_o,
  input  logic              load_en_i,
  input  logic              load_valid_i,
  input  logic [DATA_W-1:0] load_data_i,
  output logic              load_ready_o,
  output logic [ADDR_W:0]   length_o,
  output logic [DATA_W-1:0] sum_o,
  output logic              busy_o
);

  localparam int unsigned     IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_LOADING,
    S_READY
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W:0]   ptr_q, ptr_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [DATA_W-1:0] sum_q, sum_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              oob_q, oob_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic ready_w;
  logic accept_w;
  logic fetch_w;
  logic in_range_w;

  // A fetch coinciding with the start of a load is dropped: the load wins.
  always_comb begin
    ready_w    = (state_q == S_LOADING) && (ptr_q < DEPTH_L);
    accept_w   = load_valid_i && ready_w;
    fetch_w    = req_i && !load_en_i && (state_q != S_LOADING);
    in_range_w = {1'b0, address_i} < len_q;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    len_d   = len_q;
    sum_d   = sum_q;
    data_d  = data_q;
    valid_d = 1'b0;
    oob_d   = oob_q;

    unique case (state_q)
      S_EMPTY, S_READY: begin
        if (load_en_i) begin
          state_d = S_LOADING;
          ptr_d   = '0;
          sum_d   = '0;
          len_d   = '0;
        end
      end
      S_LOADING: begin
        if (accept_w) begin
          ptr_d = ptr_q + 1'b1;
          sum_d = sum_q + load_data_i;
        end
        if (!load_en_i) begin
          state_d = S_READY;
          len_d   = ptr_q;
        end
      end
      default: state_d = S_EMPTY;
    endcase

    if (fetch_w) begin
      valid_d = 1'b1;
      oob_d   = !in_range_w;
      data_d  = in_range_w ? mem[address_i[IDX_W-1:0]] : FILL;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_EMPTY;
      ptr_q   <= '0;
      len_q   <= '0;
      sum_q   <= '0;
      data_q  <= FILL;
      valid_q <= 1'b0;
      oob_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      sum_q   <= sum_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      oob_q   <= oob_d;
    end
  end

  // Array contents deliberately survive reset; length_o gates visibility.
  always_ff @(posedge clk_i) begin
    if (accept_w) begin
      mem[ptr_q[IDX_W-1:0]] <= load_data_i;
    end
  end

  assign data_o       = data_q;
  assign valid_o      = valid_q;
  assign oob_o        = oob_q;
  assign load_ready_o = ready_w;
  assign length_o     = len_q;
  assign sum_o        = sum_q;
  assign busy_o       = (state_q == S_LOADING);

endmodule
